// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and buffer state encoding for the ALU result stage
package alu_pkg;
    localparam int ALU_WIDTH = 8;
    localparam int ALU_OPW   = 3;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;
endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational zero/parity/sign flags of a result
// Ports: i_result (in), o_zero (result == 0), o_parity (odd count of ones), o_sign (MSB)
module alu_flag_gen #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_result,
    output logic             o_zero,
    output logic             o_parity,
    output logic             o_sign
);
    assign o_zero   = ~|i_result;
    assign o_parity = ^i_result;
    assign o_sign   = i_result[WIDTH-1];
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry in-order buffer for ALU results with stored flags and running XOR checksum
// Ports: clk, rst (async active-high); in_valid/in_ready/in_result/in_op upstream handshake;
//        out_valid/out_ready/out_result/out_op/out_zero/out_parity/out_sign head entry;
//        chk_clear clears checksum, checksum is the XOR of all accepted results.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [OPW-1:0]   in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OPW-1:0]   out_op,
    output logic             out_zero,
    output logic             out_parity,
    output logic             out_sign,
    input  logic             chk_clear,
    output logic [WIDTH-1:0] checksum
);
    buf_state_t       r_state;
    buf_state_t       w_next;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_head_res;
    logic [OPW-1:0]   r_head_op;
    logic             r_head_zero;
    logic             r_head_par;
    logic             r_head_sign;
    logic [WIDTH-1:0] r_tail_res;
    logic [OPW-1:0]   r_tail_op;
    logic             r_tail_zero;
    logic             r_tail_par;
    logic             r_tail_sign;
    logic [WIDTH-1:0] r_checksum;
    logic             w_zero;
    logic             w_par;
    logic             w_sign;
    logic             w_push;
    logic             w_pop;
    logic             w_load_head;
    logic             w_load_tail;
    logic             w_shift;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
        .i_result (in_result),
        .o_zero   (w_zero),
        .o_parity (w_par),
        .o_sign   (w_sign)
    );

    // Both handshake qualifiers are registers, so nothing here depends combinationally on out_ready -> in_ready.
    assign w_push = in_valid & r_in_ready;
    assign w_pop  = r_out_valid & out_ready;

    always_comb begin
        w_next      = r_state;
        w_load_head = 1'b0;
        w_load_tail = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_next      = w_push ? ST_ONE : ST_EMPTY;
                w_load_head = w_push;
            end
            ST_ONE: begin
                w_next      = (w_push && !w_pop) ? ST_FULL : (w_pop && !w_push) ? ST_EMPTY : ST_ONE;
                w_load_head = w_push && w_pop;
                w_load_tail = w_push && !w_pop;
            end
            ST_FULL: begin
                w_next  = w_pop ? ST_ONE : ST_FULL;
                w_shift = w_pop;
            end
            default: w_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next != ST_FULL);
            r_out_valid <= (w_next != ST_EMPTY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_res  <= '0;
            r_head_op   <= '0;
            r_head_zero <= 1'b0;
            r_head_par  <= 1'b0;
            r_head_sign <= 1'b0;
            r_tail_res  <= '0;
            r_tail_op   <= '0;
            r_tail_zero <= 1'b0;
            r_tail_par  <= 1'b0;
            r_tail_sign <= 1'b0;
        end else begin
            if (w_load_head) begin
                r_head_res  <= in_result;
                r_head_op   <= in_op;
                r_head_zero <= w_zero;
                r_head_par  <= w_par;
                r_head_sign <= w_sign;
            end else if (w_shift) begin
                r_head_res  <= r_tail_res;
                r_head_op   <= r_tail_op;
                r_head_zero <= r_tail_zero;
                r_head_par  <= r_tail_par;
                r_head_sign <= r_tail_sign;
            end
            if (w_load_tail) begin
                r_tail_res  <= in_result;
                r_tail_op   <= in_op;
                r_tail_zero <= w_zero;
                r_tail_par  <= w_par;
                r_tail_sign <= w_sign;
            end
        end
    end

    // A clear coinciding with a push restarts the checksum from that push's result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_checksum <= '0;
        else     r_checksum <= (chk_clear ? '0 : r_checksum) ^ (w_push ? in_result : '0);
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_head_res;
    assign out_op     = r_head_op;
    assign out_zero   = r_head_zero;
    assign out_parity = r_head_par;
    assign out_sign   = r_head_sign;
    assign checksum   = r_checksum;
endmodule
